mram_burst_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the MRAM burst controller. It grants the shared serial MRAM access path to one requester at a time and serializes that requester's start address and burst length onto the controller's serial inputs. It holds `burst_en` until the controller reports completion, then releases the grant. The block sits between the host-side request logic and the burst controller / STP-PTS path.

---
 rtl/mram_burst_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mram_burst_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mram_burst_arbiter.sv
// rtl/mram_burst_arbiter.sv - two-requester MRAM burst arbiter/serializer; optional WAIT watchdog via ARB_TIMEOUT_EN
module mram_burst_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              mode0,
    input  logic              mode1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              timeout,
    output logic              busy,
    output logic              burst_en,
    output logic              mode_sel,
    output logic              burst_len_in,
    output logic              addr_in,
    input  logic              xfer_done
);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, RELEASE} state_t;

    localparam int CNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_sr_q, addr_sr_d;
    logic [LEN_W-1:0]   len_sr_q, len_sr_d;
    logic               mode_q, mode_d;
    logic               sel_q, sel_d;
    logic               last_gnt_q, last_gnt_d;
    logic               zl_q, zl_d;

    logic               pick_v, pick_id, pick_mode;
    logic [ADDR_W-1:0]  pick_addr;
    logic [LEN_W-1:0]   pick_len;

    logic hold_gnt, done_pulse;
    logic timeout_d, busy_d, burst_en_d, mode_sel_d, len_bit_d, addr_bit_d;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // Round-robin pick: a tie goes to the requester that was not served last
    always_comb begin
        pick_v    = req0 | req1;
        pick_id   = (req0 && req1) ? ~last_gnt_q : req1;
        pick_addr = pick_id ? addr1 : addr0;
        pick_len  = pick_id ? len1  : len0;
        pick_mode = pick_id ? mode1 : mode0;
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_sr_d  = addr_sr_q;
        len_sr_d   = len_sr_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        last_gnt_d = last_gnt_q;
        zl_d       = zl_q;
        hold_gnt   = 1'b0;
        done_pulse = 1'b0;
        timeout_d  = 1'b0;
        busy_d     = 1'b0;
        burst_en_d = 1'b0;
        mode_sel_d = 1'b0;
        len_bit_d  = 1'b0;
        addr_bit_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_v) begin
                    sel_d      = pick_id;
                    mode_d     = pick_mode;
                    hold_gnt   = 1'b1;
                    busy_d     = 1'b1;
                    mode_sel_d = pick_mode;
                    if (pick_mode && (pick_len == '0)) begin
                        // Zero-length burst: nothing to send to the controller
                        zl_d    = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        zl_d       = 1'b0;
                        state_d    = SHIFT;
                        cnt_d      = '0;
                        burst_en_d = 1'b1;
                        addr_bit_d = pick_addr[ADDR_W-1];
                        addr_sr_d  = pick_addr << 1;
                        len_bit_d  = pick_mode & pick_len[LEN_W-1];
                        len_sr_d   = pick_mode ? (pick_len << 1) : '0;
                    end
                end
            end
            SHIFT: begin
                hold_gnt   = 1'b1;
                busy_d     = 1'b1;
                burst_en_d = 1'b1;
                mode_sel_d = mode_q;
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
`ifdef ARB_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    addr_bit_d = addr_sr_q[ADDR_W-1];
                    addr_sr_d  = addr_sr_q << 1;
                    len_bit_d  = len_sr_q[LEN_W-1];
                    len_sr_d   = len_sr_q << 1;
                end
            end
            WAIT: begin
                hold_gnt   = 1'b1;
                busy_d     = 1'b1;
                mode_sel_d = mode_q;
                if (xfer_done) begin
                    state_d    = RELEASE;
                    done_pulse = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d    = RELEASE;
                    done_pulse = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    burst_en_d = 1'b1;
                    wd_cnt_d   = wd_cnt_q + 1'b1;
`else
                end else begin
                    burst_en_d = 1'b1;
`endif
                end
            end
            RELEASE: begin
                // Zero-length grants report completion on the way out
                state_d    = IDLE;
                last_gnt_d = sel_q;
                done_pulse = zl_q;
                zl_d       = 1'b0;
                mode_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears every output at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_sr_q    <= '0;
            len_sr_q     <= '0;
            mode_q       <= 1'b0;
            sel_q        <= 1'b0;
            last_gnt_q   <= 1'b1;
            zl_q         <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
            burst_en     <= 1'b0;
            mode_sel     <= 1'b0;
            burst_len_in <= 1'b0;
            addr_in      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_sr_q    <= addr_sr_d;
            len_sr_q     <= len_sr_d;
            mode_q       <= mode_d;
            sel_q        <= sel_d;
            last_gnt_q   <= last_gnt_d;
            zl_q         <= zl_d;
            gnt0         <= hold_gnt & ~sel_d;
            gnt1         <= hold_gnt & sel_d;
            done0        <= done_pulse & ~sel_d;
            done1        <= done_pulse & sel_d;
            timeout      <= timeout_d;
            busy         <= busy_d;
            burst_en     <= burst_en_d;
            mode_sel     <= mode_sel_d;
            burst_len_in <= len_bit_d;
            addr_in      <= addr_bit_d;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mram_burst_arbiter.sv
// tb/tb_mram_burst_arbiter.sv - scoreboard bench for mram_burst_arbiter
module tb_mram_burst_arbiter;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;
    localparam int TO_CYC = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0, xfer_done = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [LEN_W-1:0]  len0 = '0, len1 = '0;
    logic gnt0, gnt1, done0, done1, timeout, busy, burst_en, mode_sel, burst_len_in, addr_in;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb_q[$];

    always #5 clk = ~clk;

    mram_burst_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .timeout(timeout), .busy(busy), .burst_en(burst_en), .mode_sel(mode_sel),
        .burst_len_in(burst_len_in), .addr_in(addr_in), .xfer_done(xfer_done)
    );

    function automatic logic [7:0] ctl();
        return {gnt0, gnt1, done0, done1, timeout, busy, burst_en, mode_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_bits(input logic [ADDR_W-1:0] a, input logic m, input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] lv;
        logic lb;
        lv = m ? l : '0;
        for (int j = 0; j < ADDR_W; j++) begin
            lb = (j < LEN_W) ? lv[LEN_W-1-j] : 1'b0;
            sb_q.push_back({lb, a[ADDR_W-1-j]});
        end
    endtask

    // Serial scoreboard: pop one expected {len,addr} bit pair per enabled cycle
    always @(negedge clk) begin
        logic [1:0] exp_b;
        if (rst) begin
            exp_b = 2'b00;
            if (burst_en && sb_q.size() > 0) exp_b = sb_q.pop_front();
            checks++;
            if ({burst_len_in, addr_in} !== exp_b) begin
                errors++;
                $display("FAIL serial_bits t=%0t got %b want %b", $time, {burst_len_in, addr_in}, exp_b);
            end
        end
    end

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({ctl(), burst_len_in, addr_in} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {ctl(), burst_len_in, addr_in});
        end
        rst = 1'b1;
    endtask

    task automatic test_transfer(input bit id, input logic [ADDR_W-1:0] a, input logic m,
                                 input logic [LEN_W-1:0] l, input int k, input string name);
        logic [7:0] exp_c;
        logic g, d;
        if (id) begin req1 = 1'b1; addr1 = a; mode1 = m; len1 = l; end
        else    begin req0 = 1'b1; addr0 = a; mode0 = m; len0 = l; end
        push_bits(a, m, l);
        for (int c = 1; c <= k + 2; c++) begin
            tick();
            g = (c <= k + 1);
            d = (c == k + 1);
            exp_c = {g & ~id, g & id, d & ~id, d & id, 1'b0, g, (c <= k), m & g};
            checks++;
            if (ctl() !== exp_c) begin
                errors++;
                $display("FAIL %s cycle %0d ctl got %b want %b", name, c, ctl(), exp_c);
            end
            xfer_done = (c == k) || (c == 3);
            if (c == k + 1) begin req0 = 1'b0; req1 = 1'b0; end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_bits_left got %0d want 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_round_robin();
        bit id, seen;
        req0 = 1'b1; addr0 = 8'h11; mode0 = 1'b0; len0 = 4'h7;
        req1 = 1'b1; addr1 = 8'h22; mode1 = 1'b1; len1 = 4'h2;
        for (int g = 0; g < 4; g++) begin
            id = g[0];
            push_bits(id ? addr1 : addr0, id ? mode1 : mode0, id ? len1 : len0);
            seen = 1'b0;
            for (int w = 0; w < 4 && !seen; w++) begin
                tick();
                if (gnt0 | gnt1) seen = 1'b1;
            end
            checks++;
            if (!seen || {gnt0, gnt1} !== (id ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b", g, {gnt0, gnt1}, id ? 2'b01 : 2'b10);
            end
            for (int c = 0; c < 8; c++) begin
                tick();
                checks++;
                if (gnt0 & gnt1) begin
                    errors++;
                    $display("FAIL rr_overlap got %b want not 11", {gnt0, gnt1});
                end
            end
            xfer_done = 1'b1;
            tick();
            xfer_done = 1'b0;
            checks++;
            if ({done0, done1} !== (id ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rr_done%0d got %b want %b", g, {done0, done1}, id ? 2'b01 : 2'b10);
            end
            if (g == 3) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
            checks++;
            if ({gnt0, gnt1} !== 2'b00) begin
                errors++;
                $display("FAIL rr_idle_gap%0d got %b want 00", g, {gnt0, gnt1});
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rr_bits_left got %0d want 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_zero_len();
        logic [7:0] exp_c;
        logic g, d;
        req0 = 1'b1; addr0 = 8'hFF; mode0 = 1'b1; len0 = 4'h0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            g = (c == 1);
            d = (c == 2);
            exp_c = {g, 1'b0, d, 1'b0, 1'b0, g, 1'b0, g};
            checks++;
            if (ctl() !== exp_c) begin
                errors++;
                $display("FAIL zero_len cycle %0d ctl got %b want %b", c, ctl(), exp_c);
            end
            if (c == 2) req0 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_shift();
        req0 = 1'b1; addr0 = 8'hA5; mode0 = 1'b1; len0 = 4'h3;
        push_bits(8'hA5, 1'b1, 4'h3);
        for (int c = 1; c <= 4; c++) tick();
        rst = 1'b0;
        req0 = 1'b0;
        #1;
        checks++;
        if ({ctl(), burst_len_in, addr_in} !== 10'b0) begin
            errors++;
            $display("FAIL mid_shift_reset got %b want 0", {ctl(), burst_len_in, addr_in});
        end
        sb_q.delete();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (done0 !== 1'b0) begin
                errors++;
                $display("FAIL mid_shift_no_done got %b want 0", done0);
            end
        end
        rst = 1'b1;
        tick();
        test_transfer(1'b0, 8'hA5, 1'b1, 4'h3, 10, "after_reset");
    endtask

    task automatic test_watchdog();
`ifdef ARB_TIMEOUT_EN
        logic [7:0] exp_c;
        logic g, f;
        req0 = 1'b1; addr0 = 8'h5A; mode0 = 1'b0; len0 = 4'h0;
        push_bits(8'h5A, 1'b0, 4'h0);
        for (int c = 1; c <= 30; c++) begin
            tick();
            g = (c <= 29);
            f = (c == 29);
            exp_c = {g, 1'b0, f, 1'b0, f, g, (c <= 28), 1'b0};
            checks++;
            if (ctl() !== exp_c) begin
                errors++;
                $display("FAIL watchdog cycle %0d ctl got %b want %b", c, ctl(), exp_c);
            end
            if (c == 29) req0 = 1'b0;
        end
`else
        int low_cnt, done_cnt;
        low_cnt = 0;
        done_cnt = 0;
        req0 = 1'b1; addr0 = 8'h5A; mode0 = 1'b0; len0 = 4'h0;
        push_bits(8'h5A, 1'b0, 4'h0);
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (!busy) low_cnt++;
            if (done0 | timeout) done_cnt++;
        end
        checks++;
        if (low_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL no_watchdog busy_low %0d done %0d want 0 0", low_cnt, done_cnt);
        end
        req0 = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
`endif
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_transfer(1'b0, 8'hA5, 1'b1, 4'h9, 12, "serial");
        test_transfer(1'b1, 8'h3C, 1'b0, 4'hF, 9, "single_mode");
        test_round_robin();
        test_zero_len();
        test_reset_mid_shift();
        test_watchdog();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout bench did not complete");
        $fatal(1);
    end

endmodule
